// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one i2c_top master.
// Runs one transaction at a time and returns data and status to the granted requester.
module i2c_req_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_op,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_din,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_data,
  output logic                 rsp_ack_err,
  output logic                 rsp_timeout,
  output logic                 m_newd,
  output logic                 m_op,
  output logic [6:0]           m_addr,
  output logic [7:0]           m_din,
  input  logic                 m_busy,
  input  logic                 m_done,
  input  logic                 m_ack_err,
  input  logic [7:0]           m_dout
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitStart, StWaitDone, StResp} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            op_q, op_d;
  logic [6:0]      addr_q, addr_d;
  logic [7:0]      din_q, din_d;
  logic [7:0]      data_q, data_d;
  logic            ack_q, ack_d;
  logic            to_q, to_d;

  logic [6:0]      addr_arr [NUM_REQ];
  logic [7:0]      din_arr  [NUM_REQ];
  logic            found;
  logic [IdxW-1:0] pick;
  logic [IdxW-1:0] cand;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[7*i +: 7];
      din_arr[i]  = req_din[8*i +: 8];
    end
  end

  // Search upward from ptr+1 so the last-served requester has lowest priority.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IdxW'((32'(ptr_q) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= IdxW'(NUM_REQ - 1);
      idx_q   <= '0;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    din_d   = din_q;
    data_d  = data_q;
    ack_d   = ack_q;
    to_d    = to_q;
    unique case (state_q)
      StIdle: begin
        if (found && !m_busy) begin
          idx_d   = pick;
          op_d    = req_op[pick];
          addr_d  = addr_arr[pick];
          din_d   = din_arr[pick];
          state_d = StIssue;
        end
      end
      StIssue: begin
        // The counter holds the number of cycles elapsed since the m_newd pulse.
        cnt_d   = CntW'(1);
        state_d = StWaitStart;
      end
      StWaitStart: begin
        if (cnt_q == CntLast) begin
          data_d  = '0;
          ack_d   = 1'b0;
          to_d    = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (m_busy) state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (m_done) begin
          data_d  = op_q ? m_dout : 8'h00;
          ack_d   = m_ack_err;
          to_d    = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          data_d  = '0;
          ack_d   = 1'b0;
          to_d    = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        ptr_d   = idx_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt       = '0;
    rsp_valid = '0;
    m_newd    = 1'b0;
    if (state_q != StIdle) gnt[idx_q] = 1'b1;
    if (state_q == StIssue) m_newd = 1'b1;
    if (state_q == StResp) rsp_valid[idx_q] = 1'b1;
    m_op        = op_q;
    m_addr      = addr_q;
    m_din       = din_q;
    rsp_data    = data_q;
    rsp_ack_err = ack_q;
    rsp_timeout = to_q;
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: a small behavioural i2c master model plus a response scoreboard.
module tb_i2c_req_arbiter;
  localparam int NR = 4;
  localparam int TO = 50;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req, req_op;
  logic [7*NR-1:0] req_addr;
  logic [8*NR-1:0] req_din;
  logic [NR-1:0]   gnt, rsp_valid;
  logic [7:0]      rsp_data;
  logic            rsp_ack_err, rsp_timeout;
  logic            m_newd, m_op;
  logic [6:0]      m_addr;
  logic [7:0]      m_din;
  logic            m_busy, m_done, m_ack_err;
  logic [7:0]      m_dout;
  logic            mock_busy;
  bit              ext_busy = 0;
  bit              hang = 0;
  int              busy_len = 3;

  assign m_busy = mock_busy | ext_busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  i2c_req_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_addr(req_addr), .req_din(req_din),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ack_err(rsp_ack_err),
    .rsp_timeout(rsp_timeout), .m_newd(m_newd), .m_op(m_op), .m_addr(m_addr), .m_din(m_din),
    .m_busy(m_busy), .m_done(m_done), .m_ack_err(m_ack_err), .m_dout(m_dout)
  );

  // Master model: busy for busy_len cycles after newd, then done held high until the next newd.
  logic [7:0] mem [128];
  initial begin
    logic       mop;
    logic [6:0] maddr;
    logic [7:0] mdin;
    int         left;
    bit         active;
    mock_busy = 1'b0; m_done = 1'b0; m_ack_err = 1'b0; m_dout = 8'h00;
    mop = 1'b0; maddr = '0; mdin = '0; left = 0; active = 0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        mock_busy = 1'b0; m_done = 1'b0; m_ack_err = 1'b0; active = 0;
      end else if (m_newd && !hang) begin
        m_done = 1'b0; mock_busy = 1'b1; active = 1; left = busy_len;
        mop = m_op; maddr = m_addr; mdin = m_din;
      end else if (active) begin
        left--;
        if (left <= 0) begin
          active = 0; mock_busy = 1'b0; m_done = 1'b1;
          m_ack_err = (maddr == 7'h7F);
          if (!mop && maddr != 7'h7F) mem[maddr] = mdin;
          m_dout = mop ? mem[maddr] : 8'h5A;
        end
      end
    end
  end

  typedef struct { int idx; logic [7:0] data; logic ack; logic to; int cyc; } rsp_t;
  typedef struct { logic op; logic [6:0] addr; logic [7:0] din; int cyc; } newd_t;

  rsp_t  exp_q[$];
  rsp_t  obs_q[$];
  newd_t newd_q[$];
  bit    bad_gnt = 0;
  int    keep_cnt [NR];
  int    n_chk = 0;
  int    n_fail = 0;

  function automatic int oh_idx(input logic [NR-1:0] v);
    int r = -1;
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    if (|rsp_valid) obs_q.push_back('{oh_idx(rsp_valid), rsp_data, rsp_ack_err, rsp_timeout, cyc});
    if (m_newd) newd_q.push_back('{m_op, m_addr, m_din, cyc});
    if ($countones(gnt) > 1 || (|rsp_valid && rsp_valid != gnt)) bad_gnt = 1;
  end

  // Requesters drop req after their response unless asked to re-request.
  task automatic serve(input int target, input int max_cyc, output bit ok);
    ok = 0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (rsp_valid[i]) begin
          if (keep_cnt[i] > 0) keep_cnt[i]--;
          else req[i] = 1'b0;
        end
      end
      if (obs_q.size() >= target) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic set_req(input int i, input logic op, input logic [6:0] a, input logic [7:0] d);
    req_op[i] = op;
    req_addr[7*i +: 7] = a;
    req_din[8*i +: 8] = d;
    req[i] = 1'b1;
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_op = '0; req_addr = '0; req_din = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (gnt !== 4'h0 || rsp_valid !== 4'h0 || m_newd !== 1'b0 || m_op !== 1'b0 ||
        m_addr !== 7'h00 || m_din !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: gnt=%h rsp_valid=%h newd=%b op=%b addr=%h din=%h, required all 0",
               gnt, rsp_valid, m_newd, m_op, m_addr, m_din);
    end
    n_chk++;
    if (rsp_data !== 8'h00 || rsp_ack_err !== 1'b0 || rsp_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rsp: data=%h ack=%b to=%b, required 0/0/0",
               rsp_data, rsp_ack_err, rsp_timeout);
    end
  endtask

  // One transaction from requester i, checked against the scoreboard and the master-side view.
  task automatic one_txn(input string nm, input int i, input logic op, input logic [6:0] a,
                         input logic [7:0] d, input logic [7:0] edata, input logic eack);
    int ob = obs_q.size();
    int nb = newd_q.size();
    int c0;
    bit ok;
    rsp_t e, o;
    exp_q.delete();
    @(posedge clk); #1;
    set_req(i, op, a, d);
    c0 = cyc;
    exp_q.push_back('{i, edata, eack, 1'b0, 0});
    serve(ob + 1, 200, ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_rsp_seen: got %0d responses, required 1", nm, obs_q.size() - ob);
    end else begin
      e = exp_q.pop_front();
      o = obs_q[ob];
      if (o.idx !== e.idx || o.data !== e.data || o.ack !== e.ack || o.to !== e.to) begin
        n_fail++;
        $display("FAIL %s_rsp: idx=%0d data=%h ack=%b to=%b, required idx=%0d data=%h ack=%b to=0",
                 nm, o.idx, o.data, o.ack, o.to, e.idx, e.data, e.ack);
      end
    end
    n_chk++;
    if (newd_q.size() != nb + 1) begin
      n_fail++;
      $display("FAIL %s_newd_count: got %0d, required 1", nm, newd_q.size() - nb);
    end else if (newd_q[nb].op !== op || newd_q[nb].addr !== a || newd_q[nb].din !== d ||
                 newd_q[nb].cyc != c0 + 1) begin
      n_fail++;
      $display("FAIL %s_newd: op=%b addr=%h din=%h at +%0d, required op=%b addr=%h din=%h at +1",
               nm, newd_q[nb].op, newd_q[nb].addr, newd_q[nb].din, newd_q[nb].cyc - c0, op, a, d);
    end
  endtask

  task automatic test_write_read();
    one_txn("write", 0, 1'b0, 7'h02, 8'hAA, 8'h00, 1'b0);
    one_txn("read", 0, 1'b1, 7'h02, 8'h00, 8'hAA, 1'b0);
  endtask

  task automatic test_round_robin();
    int ob, nb;
    bit ok;
    rsp_t e, o;
    pulse_rst();
    ob = obs_q.size(); nb = newd_q.size();
    exp_q.delete();
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      set_req(i, 1'b0, 7'(8'h10 + i), 8'(8'h10 + i));
      exp_q.push_back('{i, 8'h00, 1'b0, 1'b0, 0});
    end
    serve(ob + NR, 400, ok);
    repeat (10) @(negedge clk);
    n_chk++;
    if (obs_q.size() != ob + NR || newd_q.size() != nb + NR) begin
      n_fail++;
      $display("FAIL rr_count: rsp=%0d newd=%0d, required %0d each",
               obs_q.size() - ob, newd_q.size() - nb, NR);
    end else begin
      for (int k = 0; k < NR; k++) begin
        e = exp_q.pop_front();
        o = obs_q[ob + k];
        n_chk++;
        if (o.idx !== e.idx || o.ack !== 1'b0 || o.to !== 1'b0 ||
            newd_q[nb + k].din !== 8'(8'h10 + e.idx)) begin
          n_fail++;
          $display("FAIL rr_order_%0d: idx=%0d din=%h, required idx=%0d din=%h",
                   k, o.idx, newd_q[nb + k].din, e.idx, 8'(8'h10 + e.idx));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int ob = obs_q.size();
    int nb = newd_q.size();
    int eord [3] = '{1, 2, 1};
    bit ok;
    @(posedge clk); #1;
    keep_cnt[1] = 1;
    set_req(1, 1'b0, 7'h21, 8'h21);
    set_req(2, 1'b0, 7'h22, 8'h22);
    serve(ob + 3, 300, ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d responses, required 3", obs_q.size() - ob);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (obs_q[ob + k].idx != eord[k]) begin
          n_fail++;
          $display("FAIL b2b_order_%0d: idx=%0d, required %0d", k, obs_q[ob + k].idx, eord[k]);
        end
      end
      n_chk++;
      if (newd_q.size() < nb + 2 || newd_q[nb + 1].cyc != obs_q[ob].cyc + 2) begin
        n_fail++;
        $display("FAIL b2b_gap: second newd not 2 cycles after first response");
      end
    end
  endtask

  task automatic test_nack();
    one_txn("nack", 3, 1'b0, 7'h7F, 8'hC3, 8'h00, 1'b1);
    repeat (3) @(negedge clk);
    n_chk++;
    if (rsp_ack_err !== 1'b1) begin
      n_fail++;
      $display("FAIL nack_hold: rsp_ack_err=%b, required 1", rsp_ack_err);
    end
    one_txn("after_nack", 0, 1'b0, 7'h03, 8'h55, 8'h00, 1'b0);
  endtask

  task automatic test_timeout();
    int ob = obs_q.size();
    int nb = newd_q.size();
    bit ok;
    hang = 1;
    @(posedge clk); #1;
    set_req(1, 1'b0, 7'h06, 8'h66);
    serve(ob + 1, 200, ok);
    n_chk++;
    if (!ok || newd_q.size() != nb + 1) begin
      n_fail++;
      $display("FAIL timeout_seen: rsp=%0d newd=%0d, required 1 each",
               obs_q.size() - ob, newd_q.size() - nb);
    end else if (obs_q[ob].idx != 1 || obs_q[ob].to !== 1'b1 || obs_q[ob].ack !== 1'b0 ||
                 obs_q[ob].data !== 8'h00 || obs_q[ob].cyc - newd_q[nb].cyc != TO) begin
      n_fail++;
      $display("FAIL timeout_rsp: idx=%0d to=%b ack=%b data=%h after %0d, required 1/1/0/00 after %0d",
               obs_q[ob].idx, obs_q[ob].to, obs_q[ob].ack, obs_q[ob].data,
               obs_q[ob].cyc - newd_q[nb].cyc, TO);
    end
    hang = 0;
    @(negedge clk);
    n_chk++;
    if (gnt !== 4'h0 || m_newd !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_idle: gnt=%h newd=%b, required 0/0", gnt, m_newd);
    end
  endtask

  task automatic test_busy_block();
    int nb = newd_q.size();
    ext_busy = 1;
    @(posedge clk); #1;
    set_req(2, 1'b0, 7'h05, 8'h33);
    repeat (6) @(negedge clk);
    n_chk++;
    if (gnt !== 4'h0 || newd_q.size() != nb) begin
      n_fail++;
      $display("FAIL busy_block: gnt=%h newd=%0d while busy, required 0/0", gnt, newd_q.size() - nb);
    end
    #1 ext_busy = 0;
    req[2] = 1'b0;
    one_txn("busy_release", 2, 1'b0, 7'h05, 8'h33, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid();
    int ob, nb;
    bit ok;
    busy_len = 30;
    nb = newd_q.size();
    @(posedge clk); #1;
    set_req(0, 1'b1, 7'h02, 8'h00);
    for (int k = 0; k < 20 && newd_q.size() == nb; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    ob = obs_q.size();
    @(posedge clk); #1 rst = 1'b1; req = '0;
    @(posedge clk); #1 rst = 1'b0;
    busy_len = 3;
    @(negedge clk);
    n_chk++;
    if (gnt !== 4'h0 || m_newd !== 1'b0 || rsp_valid !== 4'h0 || rsp_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid_out: gnt=%h newd=%b rsp_valid=%h data=%h, required all 0",
               gnt, m_newd, rsp_valid, rsp_data);
    end
    repeat (10) @(negedge clk);
    n_chk++;
    if (obs_q.size() != ob) begin
      n_fail++;
      $display("FAIL rst_mid_norsp: got %0d responses, required 0", obs_q.size() - ob);
    end
    ob = obs_q.size();
    @(posedge clk); #1;
    set_req(3, 1'b0, 7'h13, 8'h13);
    set_req(2, 1'b0, 7'h12, 8'h12);
    serve(ob + 2, 200, ok);
    n_chk++;
    if (!ok || obs_q[ob].idx != 2 || obs_q[ob + 1].idx != 3) begin
      n_fail++;
      $display("FAIL rst_mid_ptr: %0d responses, first idx=%0d, required 2 then 3",
               obs_q.size() - ob, (obs_q.size() > ob) ? obs_q[ob].idx : -1);
    end
  endtask

  task automatic test_invariants();
    n_chk++;
    if (bad_gnt) begin
      n_fail++;
      $display("FAIL gnt_onehot: multi-hot gnt or rsp_valid outside gnt seen=%b, required 0", bad_gnt);
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) keep_cnt[i] = 0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_back_to_back();
    test_nack();
    test_timeout();
    test_busy_block();
    test_reset_mid();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d, required completion", cyc);
    $fatal(1);
  end

endmodule
